encoder_queue: RTL and testbench

- Sequential 8-to-3 encoder; the return path for the 3-to-8 `Decoder`.
- Captures event strobes on eight one-hot lines `D0`..`D7` into a pending register.
- Emits one 3-bit code (`A` = MSB, `C` = LSB) per accepted handshake on a valid/ready output.
- Sits between event sources and the consumer that re-drives a `Decoder` (code `{A,B,C}` = i selects `Di`), so the pair round-trips.

---
 rtl/encoder_queue_if.sv | 27 ++
 rtl/encoder_queue.sv | 114 +++++++++++
 tb/tb_encoder_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_queue_if.sv
// Bus bundle for encoder_queue: capture enable, event strobes, consumer
// ready, and the valid/code/status outputs. Also carries the FSM state as a
// debug signal.
//
// Handshake: a code {A,B,C} is transferred on every rising edge where V=1 and
// R=1. While V=1 and R=0 the producer holds V and {A,B,C} unchanged; V never
// drops without a transfer.
interface encoder_queue_if;
    logic       E;
    logic       D0, D1, D2, D3, D4, D5, D6, D7;
    logic       R;
    logic       V;
    logic       A, B, C;
    logic       OVF;
    logic [3:0] PEND;
    logic       state;

    modport master (
        output E, D0, D1, D2, D3, D4, D5, D6, D7, R,
        input  V, A, B, C, OVF, PEND, state
    );

    modport slave (
        input  E, D0, D1, D2, D3, D4, D5, D6, D7, R,
        output V, A, B, C, OVF, PEND, state
    );
endinterface

// File: rtl/encoder_queue.sv
// Sequential 8-to-3 encoder: event strobes D0..D7 are captured into a pending
// register and emitted one 3-bit index at a time on a valid/ready output.
// Optional feature: define ENCODER_QUEUE_RR_EN for round-robin selection
// (search starts just after the last emitted index); otherwise the lowest
// pending index always wins.
module encoder_queue (
    input  logic            clk,
    input  logic            rst_n,
    encoder_queue_if.slave  bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [7:0] p;
    logic [7:0] d_in;
    logic [7:0] cap;
    logic [7:0] clr;
    logic [7:0] p_next;
    logic       ovf_set;
    logic [0:0] state_q;
    logic [2:0] code;
    logic       ovf;
    logic [3:0] pend;
    logic       load;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
`ifdef ENCODER_QUEUE_RR_EN
    logic [2:0] last;
`endif

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    assign d_in = {bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};
    assign cap  = bus.E ? d_in : 8'd0;
    assign load = ((state_q == EMPTY) || bus.R) && (p != 8'd0);

    // Pick the next index to emit from the pending set.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef ENCODER_QUEUE_RR_EN
            idx = last + 3'd1 + 3'(k);
`else
            idx = 3'(k);
`endif
            if (!found && p[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Clear the loaded bit, then OR in new captures so a same-cycle strobe re-queues.
    always_comb begin
        clr     = load ? (8'd1 << sel) : 8'd0;
        p_next  = (p & ~clr) | cap;
        ovf_set = |(cap & p & ~clr);
    end

    // Pending register, its registered population count and the sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p    <= 8'd0;
            pend <= 4'd0;
            ovf  <= 1'b0;
        end else begin
            p    <= p_next;
            pend <= popcount(p_next);
            ovf  <= ovf | ovf_set;
        end
    end

    // Output stage FSM: EMPTY until a load, HOLD until the code is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            code    <= 3'd0;
        end else if (load) begin
            state_q <= HOLD;
            code    <= sel;
        end else if ((state_q == HOLD) && bus.R) begin
            state_q <= EMPTY;
        end
    end

`ifdef ENCODER_QUEUE_RR_EN
    // Remember the last emitted index; reset to 7 so the first search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 3'd7;
        end else if (load) begin
            last <= sel;
        end
    end
`endif

    assign bus.V     = (state_q == HOLD);
    assign bus.A     = code[2];
    assign bus.B     = code[1];
    assign bus.C     = code[0];
    assign bus.OVF   = ovf;
    assign bus.PEND  = pend;
    assign bus.state = state_q;
endmodule

// File: tb/tb_encoder_queue.sv
// Bench for encoder_queue: table of directed vectors, hand-written reset and
// round-robin sequences, and a random run against a behavioural model.
module tb_encoder_queue;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    encoder_queue_if bus ();

    encoder_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_code();
        return {29'd0, bus.A, bus.B, bus.C};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic e, input logic [7:0] d, input logic r);
        bus.E  = e;
        bus.D0 = d[0]; bus.D1 = d[1]; bus.D2 = d[2]; bus.D3 = d[3];
        bus.D4 = d[4]; bus.D5 = d[5]; bus.D6 = d[6]; bus.D7 = d[7];
        bus.R  = r;
    endtask

    // Apply inputs away from the edge, let one rising edge pass, sample after it.
    task automatic step(input logic e, input logic [7:0] d, input logic r);
        @(negedge clk);
        set_in(e, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_pend[8];
    bit         m_v;
    int         m_code;
    bit         m_ovf;
    int         m_last;
    logic [2:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_v = 0; m_code = 0; m_ovf = 0; m_last = 7;
        exp_q.delete();
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_pend[i];
        return n;
    endfunction

    function automatic int model_pick();
        int j;
`ifdef ENCODER_QUEUE_RR_EN
        for (int k = 1; k <= 8; k++) begin
            j = (m_last + k) % 8;
            if (m_pend[j]) return j;
        end
`else
        for (j = 0; j < 8; j++) if (m_pend[j]) return j;
`endif
        return 0;
    endfunction

    task automatic model_step(input bit e, input logic [7:0] d, input bit r);
        int s;
        if ((!m_v || r) && model_count() != 0) begin
            s = model_pick();
            m_pend[s] = 1'b0;
            m_v = 1; m_code = s; m_last = s;
            exp_q.push_back(3'(s));
        end else if (m_v && r) begin
            m_v = 0;
        end
        if (e) begin
            for (int i = 0; i < 8; i++) begin
                if (d[i]) begin
                    if (m_pend[i]) m_ovf = 1;
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       e;
        logic [7:0] d;
        logic       r;
        logic       v;
        logic [2:0] code;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[19];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_in(1'b0, 8'd0, 1'b0);

        //          e     d      r     v    code pend ovf
        // single strobe D3, ready high
        vecs[0]  = '{1'b1, 8'h08, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd3, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 4'd0, 1'b0};
        // D5,D1,D6 together with ready low; first load happens while V=0
        vecs[3]  = '{1'b1, 8'h62, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 4'd2, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 4'd2, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd5, 4'd1, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd6, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd6, 4'd0, 1'b0};
        // D7 occupies the output, then D2 pulsed twice two cycles apart
        vecs[9]  = '{1'b1, 8'h80, 1'b0, 1'b0, 3'd6, 4'd1, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 4'd0, 1'b0};
        vecs[11] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd7, 4'd1, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 4'd1, 1'b0};
        vecs[13] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd7, 4'd1, 1'b1};
        vecs[14] = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd2, 4'd0, 1'b1};
        vecs[15] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd2, 4'd0, 1'b1};
        vecs[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd2, 4'd0, 1'b1};
        // capture disabled: all strobes ignored
        vecs[17] = '{1'b0, 8'hFF, 1'b1, 1'b0, 3'd2, 4'd0, 1'b1};
        vecs[18] = '{1'b0, 8'hFF, 1'b0, 1'b0, 3'd2, 4'd0, 1'b1};

        do_reset();
        chk("rst_v",    int'(bus.V),    0);
        chk("rst_code", dut_code(),     0);
        chk("rst_pend", int'(bus.PEND), 0);
        chk("rst_ovf",  int'(bus.OVF),  0);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].e, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d_v", i),     int'(bus.V),     int'(vecs[i].v));
            chk($sformatf("vec%0d_state", i), int'(bus.state), int'(vecs[i].v));
            chk($sformatf("vec%0d_code", i),  dut_code(),      int'(vecs[i].code));
            chk($sformatf("vec%0d_pend", i),  int'(bus.PEND),  int'(vecs[i].pend));
            chk($sformatf("vec%0d_ovf", i),   int'(bus.OVF),   int'(vecs[i].ovf));
        end

        // ---- reset while V=1 and PEND=4, then idle ----
        do_reset();
        step(1'b1, 8'h1E, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        chk("pre_rst_v",    int'(bus.V),    1);
        chk("pre_rst_pend", int'(bus.PEND), 4);
        @(negedge clk);
        set_in(1'b0, 8'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_v",    int'(bus.V),    0);
        chk("async_rst_code", dut_code(),     0);
        chk("async_rst_pend", int'(bus.PEND), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h00, 1'b1);
            chk("post_rst_v",    int'(bus.V),    0);
            chk("post_rst_pend", int'(bus.PEND), 0);
        end

`ifdef ENCODER_QUEUE_RR_EN
        // ---- round robin: D0, D1, D7 held high, ready high ----
        begin
            int rr_exp[5] = '{0, 1, 7, 0, 1};
            do_reset();
            step(1'b1, 8'h83, 1'b1);
            chk("rr_first_v", int'(bus.V), 0);
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 8'h83, 1'b1);
                chk("rr_v",    int'(bus.V), 1);
                chk("rr_code", dut_code(),  rr_exp[i]);
            end
        end
`endif

        // ---- random run against the behavioural model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       e;
            logic [7:0] d;
            logic       r;
            logic [2:0] taken;
            e = ($urandom_range(0, 9) != 0);
            d = 8'd0;
            for (int i = 0; i < 8; i++) d[i] = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) != 0);
            if (bus.V && r) begin
                taken = 3'(dut_code());
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_take", 1, 0);
                end else begin
                    chk("rand_taken_code", int'(taken), int'(exp_q.pop_front()));
                end
            end
            model_step(e, d, r);
            step(e, d, r);
            chk("rand_v",    int'(bus.V),    int'(m_v));
            chk("rand_pend", int'(bus.PEND), model_count());
            chk("rand_ovf",  int'(bus.OVF),  int'(m_ovf));
            if (m_v) chk("rand_code", dut_code(), m_code);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
